stream_decryptor_rx: RTL and testbench

Receive-side endpoint of the LFSR stream-cipher link. It accepts a serial ciphertext bitstream under a valid/ready handshake and regenerates the keystream from the same three seeds as the transmitter. Each bit is decrypted, assembled MSB-first into bytes, and the bytes are buffered in a small FIFO toward a byte-wide consumer. It pairs with the existing bit-serial `cipher` encryptor and uses the shared keystream generator, so both ends stay bit-exact.

---
 rtl/cipher_pkg.sv | 49 ++++
 rtl/stream_decryptor_rx_if.sv | 23 ++
 rtl/keystream_gen.sv | 34 +++
 rtl/stream_decryptor_rx.sv | 91 +++++++++
 tb/tb_stream_decryptor_rx.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - LFSR widths, taps and keystream step helpers shared by cipher and stream_decryptor_rx
package cipher_pkg;

    localparam int BYTE_W = 8;
    localparam int K1_W   = 5;
    localparam int K2_W   = 7;
    localparam int K3_W   = 9;

    localparam int T1A = 4;
    localparam int T1B = 2;
    localparam int T2A = 6;
    localparam int T2B = 5;
    localparam int T3A = 8;
    localparam int T3B = 4;

    // An all-zero seed would lock an LFSR at zero, so it is replaced by all-ones.
    localparam logic [K1_W-1:0] ZERO_SUB1 = '1;
    localparam logic [K2_W-1:0] ZERO_SUB2 = '1;
    localparam logic [K3_W-1:0] ZERO_SUB3 = '1;

    typedef struct packed {
        logic [K1_W-1:0] r1;
        logic [K2_W-1:0] r2;
        logic [K3_W-1:0] r3;
    } lfsr_state_t;

    function automatic lfsr_state_t seed_state(input logic [K1_W-1:0] k1,
                                               input logic [K2_W-1:0] k2,
                                               input logic [K3_W-1:0] k3);
        lfsr_state_t s;
        s.r1 = (k1 == '0) ? ZERO_SUB1 : k1;
        s.r2 = (k2 == '0) ? ZERO_SUB2 : k2;
        s.r3 = (k3 == '0) ? ZERO_SUB3 : k3;
        return s;
    endfunction

    function automatic logic ks_bit(input lfsr_state_t s);
        return s.r1[K1_W-1] ^ s.r2[K2_W-1] ^ s.r3[K3_W-1];
    endfunction

    function automatic lfsr_state_t ks_step(input lfsr_state_t s);
        lfsr_state_t n;
        n.r1 = {s.r1[K1_W-2:0], s.r1[T1A] ^ s.r1[T1B]};
        n.r2 = {s.r2[K2_W-2:0], s.r2[T2A] ^ s.r2[T2B]};
        n.r3 = {s.r3[K3_W-2:0], s.r3[T3A] ^ s.r3[T3B]};
        return n;
    endfunction

endpackage

// File: rtl/stream_decryptor_rx_if.sv
// rtl/stream_decryptor_rx_if.sv - ciphertext bit stream in, plaintext byte stream out
interface stream_decryptor_rx_if;
    import cipher_pkg::*;

    logic              ct_valid;
    logic              ct_bit;
    logic              ct_sof;
    logic              ct_ready;
    logic              out_valid;
    logic [BYTE_W-1:0] out_data;
    logic              out_ready;
    logic              partial_drop;

    modport master (
        output ct_valid, ct_bit, ct_sof, out_ready,
        input  ct_ready, out_valid, out_data, partial_drop
    );

    modport slave (
        input  ct_valid, ct_bit, ct_sof, out_ready,
        output ct_ready, out_valid, out_data, partial_drop
    );
endinterface

// File: rtl/keystream_gen.sv
// rtl/keystream_gen.sv - three-LFSR keystream generator, bit-identical on both link ends
module keystream_gen
    import cipher_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            step,
    input  logic [K1_W-1:0] key1,
    input  logic [K2_W-1:0] key2,
    input  logic [K3_W-1:0] key3,
    output logic            ks
);

    lfsr_state_t r_state;
    lfsr_state_t w_seed;
    lfsr_state_t w_cur;

    // On load the current bit already comes from the seed so a resync bit uses it.
    assign w_seed = seed_state(key1, key2, key3);
    assign w_cur  = load ? w_seed : r_state;
    assign ks     = ks_bit(w_cur);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= w_seed;
        end else if (step) begin
            r_state <= ks_step(w_cur);
        end else if (load) begin
            r_state <= w_seed;
        end
    end

endmodule

// File: rtl/stream_decryptor_rx.sv
// rtl/stream_decryptor_rx.sv - serial stream-cipher receiver with byte assembly and output FIFO
module stream_decryptor_rx
    import cipher_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [K1_W-1:0]      key1,
    input  logic [K2_W-1:0]      key2,
    input  logic [K3_W-1:0]      key3,
    stream_decryptor_rx_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [BYTE_W-1:0]  r_mem [DEPTH];
    logic [2:0]         r_cnt;
    logic [BYTE_W-2:0]  r_asm;
    logic               r_drop;

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_resync;
    logic w_push;
    logic w_pop;
    logic w_ks;
    logic w_pt;

    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_accept = bus.ct_valid && !w_full;
    assign w_resync = w_accept && bus.ct_sof;
    assign w_pt     = bus.ct_bit ^ w_ks;
    assign w_push   = w_accept && !bus.ct_sof && (r_cnt == 3'd7);
    assign w_pop    = !w_empty && bus.out_ready;

    keystream_gen u_ks (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_resync),
        .step    (w_accept),
        .key1    (key1),
        .key2    (key2),
        .key3    (key3),
        .ks      (w_ks)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_asm    <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_resync && (r_cnt != 3'd0);
            if (w_accept) begin
                // A frame start restarts assembly with this bit as byte bit 7.
                if (bus.ct_sof) begin
                    r_cnt <= 3'd1;
                    r_asm <= {{(BYTE_W-2){1'b0}}, w_pt};
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                    r_asm <= {r_asm[BYTE_W-3:0], w_pt};
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {r_asm, w_pt};
        end
    end

    assign bus.ct_ready     = !w_full;
    assign bus.out_valid    = !w_empty;
    assign bus.out_data     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign bus.partial_drop = r_drop;

endmodule

// File: tb/tb_stream_decryptor_rx.sv
// tb/tb_stream_decryptor_rx.sv - randomized self-checking bench against a queue-based receiver model
module tb_stream_decryptor_rx;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic [4:0] key1;
    logic [6:0] key2;
    logic [8:0] key3;

    stream_decryptor_rx_if bus ();

    stream_decryptor_rx #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .key1    (key1),
        .key2    (key2),
        .key3    (key3),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int drops    = 0;

    // Model state: three LFSRs as plain integers, bit count, partial byte, FIFO as a queue.
    int         m_r1, m_r2, m_r3;
    int         m_cnt, m_asm;
    bit         m_drop, m_acc, m_known;
    logic [7:0] mq[$];
    logic [7:0] got[$];

    function automatic int seedv(int k, int w);
        return (k == 0) ? ((1 << w) - 1) : k;
    endfunction

    function automatic int msb(int r, int w);
        return (r >> (w - 1)) & 1;
    endfunction

    function automatic int lstep(int r, int w, int ta, int tb);
        int fb;
        fb = ((r >> ta) ^ (r >> tb)) & 1;
        return ((r << 1) | fb) & ((1 << w) - 1);
    endfunction

    // Keystream byte number j after loading the given keys.
    function automatic int ks_byte(int k1, int k2, int k3, int j);
        int a, b, c, v;
        a = seedv(k1, 5); b = seedv(k2, 7); c = seedv(k3, 9); v = 0;
        for (int i = 0; i < 8 * (j + 1); i++) begin
            v = ((v << 1) | (msb(a, 5) ^ msb(b, 7) ^ msb(c, 9))) & 8'hFF;
            a = lstep(a, 5, 4, 2); b = lstep(b, 7, 6, 5); c = lstep(c, 9, 8, 4);
        end
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit v, input bit b, input bit sof, input bit ordy, input bit rst);
        int ks, pt;
        bit exp_valid;
        exp_valid = (mq.size() > 0);
        if (m_known) begin
            chk("ct_ready", bus.ct_ready, mq.size() < DEPTH);
            chk("out_valid", bus.out_valid, exp_valid);
            chk("out_data", bus.out_data, exp_valid ? mq[0] : 0);
            chk("partial_drop", bus.partial_drop, m_drop);
        end
        bus.ct_valid  = v;
        bus.ct_bit    = b;
        bus.ct_sof    = sof;
        bus.out_ready = ordy;
        reset_n       = rst;
        if (bus.out_valid === 1'b1 && ordy) got.push_back(bus.out_data);
        if (bus.partial_drop === 1'b1) drops++;
        m_acc = 0;
        if (!rst) begin
            mq.delete();
            m_cnt = 0; m_asm = 0; m_drop = 0; m_known = 1;
            m_r1 = seedv(key1, 5); m_r2 = seedv(key2, 7); m_r3 = seedv(key3, 9);
        end else begin
            m_acc  = v && (mq.size() < DEPTH);
            m_drop = 0;
            if (exp_valid && ordy) void'(mq.pop_front());
            if (m_acc) begin
                if (sof) begin
                    m_drop = (m_cnt != 0);
                    m_cnt = 0; m_asm = 0;
                    m_r1 = seedv(key1, 5); m_r2 = seedv(key2, 7); m_r3 = seedv(key3, 9);
                end
                ks = msb(m_r1, 5) ^ msb(m_r2, 7) ^ msb(m_r3, 9);
                pt = b ^ ks;
                m_r1 = lstep(m_r1, 5, 4, 2); m_r2 = lstep(m_r2, 7, 6, 5); m_r3 = lstep(m_r3, 9, 8, 4);
                m_asm = ((m_asm << 1) | pt) & 8'hFF;
                m_cnt++;
                if (m_cnt == 8) begin
                    mq.push_back(m_asm[7:0]);
                    m_cnt = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input bit sof, input bit ordy);
        int n = 0;
        do begin
            cycle(1'b1, b, sof, ordy, 1'b1);
            n++;
        end while (!m_acc && n < 40);
        if (!m_acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] c, input bit sof);
        for (int i = 7; i >= 0; i--) send_bit(c[i], sof && (i == 7), 1'b1);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, ordy, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    logic [7:0] ct[5];

    initial begin
        clk = 0; m_known = 0; m_drop = 0;
        bus.ct_valid = 0; bus.ct_bit = 0; bus.ct_sof = 0; bus.out_ready = 1;
        key1 = 5'h15; key2 = 7'h65; key3 = 9'h14b; reset_n = 0;
        @(negedge clk);

        // Known vector and reset values
        do_reset();
        chk("rst_ct_ready", bus.ct_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("model_ks_c7", ks_byte(5'h15, 7'h65, 9'h14b, 0), 8'hC7);
        got.delete(); drops = 0;
        send_byte(8'h6B, 1'b0);
        chk("vec_latency_valid", bus.out_valid, 1);
        idle(3, 1'b1);
        chk("vec_count", got.size(), 1);
        chk("vec_byte", (got.size() > 0) ? got[0] : 0, 8'hAC);

        // Stall between bits 3 and 4
        do_reset();
        got.delete();
        for (int i = 7; i >= 5; i--) send_bit(1'((8'h6B >> i) & 1), 1'b0, 1'b1);
        idle(3, 1'b1);
        for (int i = 4; i >= 0; i--) send_bit(1'((8'h6B >> i) & 1), 1'b0, 1'b1);
        idle(3, 1'b1);
        chk("stall_byte", (got.size() == 1) ? got[0] : -1, 8'hAC);

        // Mid-byte resync
        got.delete(); drops = 0;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        send_byte(8'h6B, 1'b1);
        idle(3, 1'b1);
        chk("resync_drops", drops, 1);
        chk("resync_byte", (got.size() == 1) ? got[0] : -1, 8'hAC);

        // Reset mid-byte
        got.delete(); drops = 0;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_ct_ready", bus.ct_ready, 1);
        send_byte(8'h6B, 1'b0);
        idle(3, 1'b1);
        chk("midrst_drops", drops, 0);
        chk("midrst_byte", (got.size() == 1) ? got[0] : -1, 8'hAC);

        // FIFO full with consumer stalled, then drain
        do_reset();
        got.delete();
        for (int j = 0; j < 5; j++) ct[j] = 8'($urandom);
        for (int j = 0; j < 4; j++)
            for (int i = 7; i >= 0; i--) send_bit(ct[j][i], 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("full_ct_ready", bus.ct_ready, 0);
        chk("full_head", bus.out_data, ct[0] ^ ks_byte(5'h15, 7'h65, 9'h14b, 0));
        for (int i = 7; i >= 0; i--) send_bit(ct[4][i], 1'b0, 1'b1);
        idle(12, 1'b1);
        chk("drain_count", got.size(), 5);
        for (int j = 0; j < 5; j++)
            chk("drain_order", (got.size() > j) ? got[j] : -1, ct[j] ^ ks_byte(5'h15, 7'h65, 9'h14b, j));

        // Zero keys load as all-ones
        key1 = 0; key2 = 0; key3 = 0;
        do_reset();
        got.delete();
        chk("model_ks_f9", ks_byte(0, 0, 0, 0), 8'hF9);
        send_byte(8'h00, 1'b0);
        idle(3, 1'b1);
        chk("zero_key_byte", (got.size() == 1) ? got[0] : -1, 8'hF9);

        // Random traffic with key churn, occasional resync and reset
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                key1 = 5'($urandom); key2 = 7'($urandom); key3 = 9'($urandom);
            end
            cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 599) != 0);
        end
        idle(10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
